// File: rtl/arb_pkg.sv
// Shared types and constants for call_arbiter and its round-robin picker.
// Optional timeout support is selected with the CALL_TIMEOUT_EN macro in call_arbiter.
package arb_pkg;

  localparam int unsigned STATE_W         = 3;
  localparam int unsigned CNT_W           = 16;
  localparam int unsigned TIMEOUT_DEFAULT = 255;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    ARM   = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_e;

  // Index width that stays legal for a single requester.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/call_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping mod N.
module rr_picker
  import arb_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_found_c,
  output logic [IW-1:0] o_idx_c
);

  int unsigned w_off;
  int unsigned w_best;

  // Distance from ptr, wrapping; the smallest distance wins.
  always_comb begin
    o_found_c = 1'b0;
    o_idx_c   = '0;
    w_off     = 0;
    w_best    = N;
    for (int unsigned j = 0; j < N; j++) begin
      w_off = (j >= 32'(i_ptr)) ? (j - 32'(i_ptr)) : (j + N - 32'(i_ptr));
      if (i_req[j] && (w_off < w_best)) begin
        w_best    = w_off;
        o_found_c = 1'b1;
        o_idx_c   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/call_arbiter.sv
// Round-robin arbiter sharing one start/done function unit among N requesters.
// Define CALL_TIMEOUT_EN to abort calls that stay in ARM/WAIT for TIMEOUT cycles.
module call_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned W       = 32,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N-1:0]              req_valid,
  input  logic [N*W-1:0]            req_a,
  input  logic [N*W-1:0]            req_b,
  output logic [N-1:0]              resp_valid,
  output logic [W-1:0]              resp_result,
  output logic                      resp_err,
  output logic                      fu_start,
  output logic [W-1:0]              fu_a,
  output logic [W-1:0]              fu_b,
  input  logic [W-1:0]              fu_result,
  input  logic                      fu_done,
  output logic                      busy,
  output logic [idx_width(N)-1:0]   grant_id
);

  localparam int unsigned IW = idx_width(N);

  state_e          r_state, w_state_nxt;
  logic [IW-1:0]   r_rr_ptr, w_rr_nxt;
  logic [IW-1:0]   r_grant_id, w_grant_nxt;
  logic            r_fu_start, w_fu_start_nxt;
  logic [W-1:0]    r_fu_a, w_fu_a_nxt;
  logic [W-1:0]    r_fu_b, w_fu_b_nxt;
  logic [N-1:0]    r_resp_valid, w_resp_valid_nxt;
  logic [W-1:0]    r_resp_result, w_resp_result_nxt;
  logic            r_resp_err, w_resp_err_nxt;
  logic            r_busy;
  logic            w_found_c;
  logic [IW-1:0]   w_idx_c;
  logic            w_fin;
  logic            w_abort;
  logic            w_timeout;

`ifdef CALL_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  assign w_timeout = ((r_cnt + CNT_W'(1)) == CNT_W'(TIMEOUT));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT;
  assign w_timeout        = 1'b0;
`endif

  rr_picker #(.N(N), .IW(IW)) u_picker (
    .i_req     (req_valid),
    .i_ptr     (r_rr_ptr),
    .o_found_c (w_found_c),
    .o_idx_c   (w_idx_c)
  );

  // Next-state and next-output logic; all outputs are registered below.
  always_comb begin
    w_state_nxt       = r_state;
    w_rr_nxt          = r_rr_ptr;
    w_grant_nxt       = r_grant_id;
    w_fu_start_nxt    = 1'b0;
    w_fu_a_nxt        = r_fu_a;
    w_fu_b_nxt        = r_fu_b;
    w_resp_valid_nxt  = '0;
    w_resp_result_nxt = r_resp_result;
    w_resp_err_nxt    = r_resp_err;
    w_fin             = 1'b0;
    w_abort           = 1'b0;
`ifdef CALL_TIMEOUT_EN
    w_cnt_nxt         = r_cnt;
`endif
    case (r_state)
      IDLE: begin
        if (w_found_c) begin
          w_state_nxt    = ISSUE;
          w_fu_start_nxt = 1'b1;
          w_grant_nxt    = w_idx_c;
          for (int unsigned j = 0; j < N; j++) begin
            if (w_idx_c == IW'(j)) begin
              w_fu_a_nxt = req_a[j*W +: W];
              w_fu_b_nxt = req_b[j*W +: W];
            end
          end
        end
      end
      ISSUE: w_state_nxt = ARM;
      // A low done proves the unit took the call and dropped any stale done.
      ARM: begin
        if (w_timeout)     w_abort = 1'b1;
        else if (!fu_done) w_state_nxt = WAIT;
      end
      WAIT: begin
        if (fu_done)        w_fin   = 1'b1;
        else if (w_timeout) w_abort = 1'b1;
      end
      RESP: begin
        w_state_nxt = IDLE;
        w_rr_nxt    = (r_grant_id == IW'(N - 1)) ? '0 : (r_grant_id + IW'(1));
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_fin || w_abort) begin
      w_state_nxt       = RESP;
      w_resp_result_nxt = w_fin ? fu_result : '0;
      w_resp_err_nxt    = w_abort;
      for (int unsigned j = 0; j < N; j++) begin
        w_resp_valid_nxt[j] = (r_grant_id == IW'(j));
      end
    end

`ifdef CALL_TIMEOUT_EN
    if (r_state == ISSUE)                         w_cnt_nxt = '0;
    else if ((r_state == ARM) || (r_state == WAIT)) w_cnt_nxt = r_cnt + CNT_W'(1);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_rr_ptr      <= '0;
      r_grant_id    <= '0;
      r_fu_start    <= 1'b0;
      r_fu_a        <= '0;
      r_fu_b        <= '0;
      r_resp_valid  <= '0;
      r_resp_result <= '0;
      r_resp_err    <= 1'b0;
      r_busy        <= 1'b0;
`ifdef CALL_TIMEOUT_EN
      r_cnt         <= '0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_rr_ptr      <= w_rr_nxt;
      r_grant_id    <= w_grant_nxt;
      r_fu_start    <= w_fu_start_nxt;
      r_fu_a        <= w_fu_a_nxt;
      r_fu_b        <= w_fu_b_nxt;
      r_resp_valid  <= w_resp_valid_nxt;
      r_resp_result <= w_resp_result_nxt;
      r_resp_err    <= w_resp_err_nxt;
      r_busy        <= (w_state_nxt != IDLE);
`ifdef CALL_TIMEOUT_EN
      r_cnt         <= w_cnt_nxt;
`endif
    end
  end

  assign resp_valid  = r_resp_valid;
  assign resp_result = r_resp_result;
  assign resp_err    = r_resp_err;
  assign fu_start    = r_fu_start;
  assign fu_a        = r_fu_a;
  assign fu_b        = r_fu_b;
  assign busy        = r_busy;
  assign grant_id    = r_grant_id;

endmodule
